// File: rtl/rr_reg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_reg_arb_pkg
//  Description : Shared types and helpers for the round-robin register
//                arbiter: FSM state encoding and a generic rotate-priority
//                pick function usable by any arbiter up to 32 requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_reg_arb_pkg;

  localparam int c_pick_max_n = 32;
  localparam int c_pick_idx_w = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                    found;
    logic [c_pick_idx_w-1:0] idx;
  } pick_t;

  // First requester at or after ptr (wrapping modulo n); found=0 when none.
  function automatic pick_t rr_pick(input logic [c_pick_max_n-1:0] req,
                                    input int n,
                                    input int ptr);
    pick_t r;
    int    j;
    r = '0;
    for (int k = c_pick_max_n - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (ptr + k) % n;
        if (req[j[c_pick_idx_w-1:0]]) begin
          r.found = 1'b1;
          r.idx   = j[c_pick_idx_w-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_reg_arbiter_if
//  Description : Request/grant/data bundle between requesters (master side)
//                and the shared-register arbiter (slave side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_reg_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int c_idx_w = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ*DATA_W-1:0] din;
  logic [N_REQ-1:0]        gnt;
  logic [c_idx_w-1:0]      owner;
  logic [DATA_W-1:0]       dout;
  logic                    dout_vld;

  modport master (
    output req, lock, din,
    input  gnt, owner, dout, dout_vld
  );

  modport slave (
    input  req, lock, din,
    output gnt, owner, dout, dout_vld
  );

endinterface
`default_nettype wire

// File: rtl/rr_reg_arbiter_pick_rot.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick_rot
//  Description : Combinational rotate-priority encoder. Returns the first
//                asserted request at or after i_ptr, wrapping modulo N.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_rot #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  wire logic [N-1:0] i_req,
  input  wire logic [W-1:0] i_ptr,
  output logic      [W-1:0] o_idx,
  output logic              o_found
);

  localparam logic [W:0] c_n = (W+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [W-1:0]   w_off;
  logic [W:0]     w_sum;

  // Rotate so that bit 0 corresponds to the requester at i_ptr.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  // Lowest set bit of the rotated vector is the winning offset from i_ptr.
  always_comb begin
    w_off   = '0;
    o_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off   = k[W-1:0];
        o_found = 1'b1;
      end
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    o_idx = (w_sum >= c_n) ? W'(w_sum - c_n) : w_sum[W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/rr_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_reg_arbiter
//  Description : Round-robin arbiter owning one shared DATA_W holding
//                register. One grant per cycle; a locked owner may keep the
//                grant for at most MAX_HOLD consecutive cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_reg_arbiter
  import rr_reg_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input wire logic         clk,
  input wire logic         rst,
  rr_reg_arbiter_if.slave  bus
);

  localparam int c_idx_w    = $clog2(N_REQ);
  localparam int c_hc_w     = $clog2(MAX_HOLD + 1);
  localparam int c_wait_max = (N_REQ - 1) * MAX_HOLD;
  localparam int c_wait_w   = $clog2(c_wait_max + 2);

  localparam logic [c_hc_w-1:0]  c_hold_last = c_hc_w'(MAX_HOLD - 1);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(N_REQ - 1);

  arb_state_t           r_state,    w_state_nxt;
  logic [c_idx_w-1:0]   r_ptr,      w_ptr_nxt;
  logic [c_hc_w-1:0]    r_hold_cnt, w_hold_nxt;
  logic [N_REQ-1:0]     r_gnt,      w_gnt_nxt;
  logic [c_idx_w-1:0]   r_owner,    w_owner_nxt;
  logic [DATA_W-1:0]    r_dout,     w_dout_nxt;
  logic                 r_vld,      w_vld_nxt;

  logic [c_idx_w-1:0]   w_win;
  logic                 w_found;
  logic                 w_keep;
  logic [DATA_W-1:0]    w_din_arr [N_REQ];

  // Unpack the flat requester data bus into one word per requester.
  for (genvar i = 0; i < N_REQ; i++) begin : g_din
    assign w_din_arr[i] = bus.din[i*DATA_W +: DATA_W];
  end

  rr_pick_rot #(
    .N (N_REQ)
  ) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  // The owner extends its burst only while it still requests, asks for the
  // lock, and has not yet used MAX_HOLD consecutive cycles.
  assign w_keep = (r_state == OWNED) && bus.req[r_owner] && bus.lock[r_owner]
                  && (r_hold_cnt < c_hold_last);

  // Next-state: extend the burst, rearbitrate in the same edge, or go idle.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold_cnt;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_dout_nxt  = r_dout;
    w_vld_nxt   = r_vld;
    if (w_keep) begin
      w_state_nxt = OWNED;
      w_hold_nxt  = r_hold_cnt + c_hc_w'(1);
      w_dout_nxt  = w_din_arr[r_owner];
      w_vld_nxt   = 1'b1;
    end else if (w_found) begin
      w_state_nxt      = OWNED;
      w_gnt_nxt        = '0;
      w_gnt_nxt[w_win] = 1'b1;
      w_owner_nxt      = w_win;
      w_dout_nxt       = w_din_arr[w_win];
      w_vld_nxt        = 1'b1;
      w_ptr_nxt        = (w_win == c_last_idx) ? '0 : w_win + c_idx_w'(1);
      w_hold_nxt       = '0;
    end else begin
      w_state_nxt = IDLE;
      w_gnt_nxt   = '0;
      w_vld_nxt   = 1'b0;
      w_hold_nxt  = '0;
    end
  end

  // State, pointer, burst counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_dout     <= '0;
      r_vld      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gnt      <= w_gnt_nxt;
      r_owner    <= w_owner_nxt;
      r_dout     <= w_dout_nxt;
      r_vld      <= w_vld_nxt;
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.owner    = r_owner;
  assign bus.dout     = r_dout;
  assign bus.dout_vld = r_vld;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  logic [c_pick_max_n-1:0] w_req_ext;
  pick_t                   w_ref_pick;

  // Zero-extended request vector for the generic reference picker.
  always_comb begin
    w_req_ext              = '0;
    w_req_ext[N_REQ-1:0]   = bus.req;
    w_ref_pick             = rr_pick(w_req_ext, N_REQ, int'(r_ptr));
  end

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(r_gnt));
  a_vld_is_gnt  : assert property (@(posedge clk) disable iff (rst)
    r_vld == (|r_gnt));
  a_owner_gnt   : assert property (@(posedge clk) disable iff (rst)
    r_vld |-> r_gnt[r_owner]);
  a_hold_bound  : assert property (@(posedge clk) disable iff (rst)
    r_hold_cnt <= c_hold_last);
  a_pick_agrees : assert property (@(posedge clk) disable iff (rst)
    (w_ref_pick.found == w_found) &&
    (!w_found || (w_ref_pick.idx == c_pick_idx_w'(w_win))));

  // Per-requester wait counter bounding starvation of a held request.
  for (genvar i = 0; i < N_REQ; i++) begin : g_wait
    logic [c_wait_w-1:0] r_wait;

    // Count edges where requester i asked but the grant went elsewhere.
    always_ff @(posedge clk) begin
      if (rst || !bus.req[i] || w_gnt_nxt[i]) begin
        r_wait <= '0;
      end else if (r_wait != '1) begin
        r_wait <= r_wait + c_wait_w'(1);
      end
    end

    a_no_starve : assert property (@(posedge clk) disable iff (rst)
      r_wait <= c_wait_w'(c_wait_max));
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_reg_arbiter
//  Description : Self-checking bench for rr_reg_arbiter: directed scenarios
//                with fixed expectations plus randomized traffic compared
//                against a burst-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_reg_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: who owns the register and for how many cycles.
  bit         m_busy;
  int         m_owner;
  int         m_ptr;
  int         m_run;
  logic [7:0] m_dout;
  bit         m_vld;

  rr_reg_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  rr_reg_arbiter #(
    .N_REQ    (N),
    .DATA_W   (DW),
    .MAX_HOLD (MH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock of the arbitration rules, expressed as bursts of length <= MH.
  task automatic model(input bit r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [31:0] d);
    int w;
    if (r) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_run = 0; m_dout = '0; m_vld = 0;
    end else if (m_busy && rq[m_owner] && lk[m_owner] && m_run < MH) begin
      m_run++;
      m_dout = d[m_owner*8 +: 8];
      m_vld  = 1;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_busy  = 1;
        m_owner = w;
        m_dout  = d[w*8 +: 8];
        m_vld   = 1;
        m_ptr   = (w + 1) % N;
        m_run   = 1;
      end else begin
        m_busy = 0;
        m_vld  = 0;
        m_run  = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, compare after the edge.
  task automatic step(input string tag, input bit r, input logic [3:0] rq,
                      input logic [3:0] lk, input logic [31:0] d);
    rst      = r;
    bus.req  = rq;
    bus.lock = lk;
    bus.din  = d;
    model(r, rq, lk, d);
    @(posedge clk);
    #1;
    check({tag, ".gnt"},   32'(bus.gnt),      m_vld ? (32'd1 << m_owner) : 32'd0);
    check({tag, ".vld"},   32'(bus.dout_vld), 32'(m_vld));
    check({tag, ".dout"},  32'(bus.dout),     32'(m_dout));
    check({tag, ".owner"}, 32'(bus.owner),    32'(m_owner));
  endtask

  logic [31:0] d_base;
  logic [3:0]  exp_g [6];
  logic [7:0]  exp_d [6];

  initial begin
    d_base = 32'h13121110;

    // Reset holds everything at zero despite full requests.
    for (int i = 0; i < 3; i++) begin
      step("t1", 1'b1, 4'b1111, 4'b0000, d_base);
      check("t1.gnt_zero", 32'(bus.gnt), 32'd0);
      check("t1.dout_zero", 32'(bus.dout), 32'd0);
    end

    // Plain rotation through all requesters.
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h00};
    for (int i = 0; i < 5; i++) begin
      step("t2", 1'b0, 4'b1111, 4'b0000, d_base);
      check("t2.gnt_seq", 32'(bus.gnt), 32'(exp_g[i]));
      check("t2.dout_seq", 32'(bus.dout), 32'(exp_d[i]));
    end

    // Locked burst capped at MH cycles, data tracks the owner each cycle.
    step("t3r", 1'b1, 4'b0000, 4'b0000, d_base);
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      step("t3", 1'b0, 4'b0101, 4'b0001, {d_base[31:8], 8'(8'h20 + i)});
      check("t3.gnt_seq", 32'(bus.gnt), 32'(exp_g[i]));
      if (exp_g[i] == 4'b0001) check("t3.dout_track", 32'(bus.dout), 32'h20 + i);
    end

    // Owner dropping its request ends the burst even with lock set.
    step("t4r", 1'b1, 4'b0000, 4'b0000, d_base);
    step("t4a", 1'b0, 4'b0100, 4'b0100, d_base);
    step("t4b", 1'b0, 4'b1001, 4'b0100, d_base);
    check("t4.gnt", 32'(bus.gnt), 32'b1000);
    check("t4.owner", 32'(bus.owner), 32'd3);

    // Idle keeps dout and owner; scan resumes after the last winner.
    step("t5r", 1'b1, 4'b0000, 4'b0000, d_base);
    step("t5a", 1'b0, 4'b0010, 4'b0000, 32'h0000A500);
    step("t5b", 1'b0, 4'b0000, 4'b0000, 32'h00000000);
    check("t5.idle_gnt", 32'(bus.gnt), 32'd0);
    check("t5.idle_vld", 32'(bus.dout_vld), 32'd0);
    check("t5.held_dout", 32'(bus.dout), 32'hA5);
    step("t5c", 1'b0, 4'b0011, 4'b0000, d_base);
    check("t5.wrap_gnt", 32'(bus.gnt), 32'b0001);

    // Reset in the middle of a locked burst drops ownership immediately.
    step("t6r", 1'b1, 4'b0000, 4'b0000, d_base);
    for (int i = 0; i < 3; i++) step("t6a", 1'b0, 4'b0001, 4'b0001, d_base);
    step("t6b", 1'b1, 4'b0001, 4'b0001, d_base);
    check("t6.rst_gnt", 32'(bus.gnt), 32'd0);
    check("t6.rst_owner", 32'(bus.owner), 32'd0);
    step("t6c", 1'b0, 4'b1010, 4'b0000, d_base);
    check("t6.after_gnt", 32'(bus.gnt), 32'b0010);

    // Randomized traffic with frequent locks and rare resets.
    for (int i = 0; i < 3000; i++) begin
      step("rnd",
           ($urandom_range(0, 63) == 0),
           4'($urandom),
           ($urandom_range(0, 3) != 0) ? 4'b1111 : 4'($urandom),
           $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
